// File: rtl/wbr_scan_ctrl.sv
// wbr_scan_ctrl: load -> capture -> unload sequencer for one WC_SF1_CII
// wrapper boundary register segment (serial in WPSI, serial out WPSO).
// Optional compare logic: define WBR_SCAN_CTRL_COMPARE_EN to add
// expected/mask inputs and a registered fail flag.
module wbr_scan_ctrl #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 capture_en,
    input  logic [CHAIN_LEN-1:0] pattern,
`ifdef WBR_SCAN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic                 fail,
`endif
    output logic                 wse_outputs,
    output logic                 hold_outputs,
    output logic                 WPSI,
    input  logic                 WPSO,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CNT_W-1:0]     cnt;
    logic                 cap_q;
    logic                 last_shift;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] expected_q;
    logic [CHAIN_LEN-1:0] mask_q;
`endif

    assign last_shift = (cnt == CNT_W'(CHAIN_LEN - 1));
    assign WPSI       = sreg[CHAIN_LEN-1];

    // State register
    always_ff @(posedge CLK) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next-state and Moore output decode; abort beats start and any shift progress
    always_comb begin
        state_n      = state;
        wse_outputs  = 1'b0;
        hold_outputs = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_n = S_LOAD;
            end
            S_LOAD: begin
                wse_outputs  = 1'b1;
                hold_outputs = 1'b0;
                busy         = 1'b1;
                if (abort)           state_n = S_IDLE;
                else if (last_shift) state_n = cap_q ? S_CAPTURE : S_DONE;
            end
            S_CAPTURE: begin
                hold_outputs = 1'b0;
                busy         = 1'b1;
                state_n      = abort ? S_IDLE : S_UNLOAD;
            end
            S_UNLOAD: begin
                wse_outputs  = 1'b1;
                hold_outputs = 1'b0;
                busy         = 1'b1;
                if (abort)           state_n = S_IDLE;
                else if (last_shift) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Shift register, counter, request latches and the held result registers
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            sreg       <= '0;
            cnt        <= '0;
            cap_q      <= 1'b0;
            response   <= '0;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
            expected_q <= '0;
            mask_q     <= '0;
            fail       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        sreg       <= pattern;
                        cnt        <= '0;
                        cap_q      <= capture_en;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
                        expected_q <= expected;
                        mask_q     <= mask;
`endif
                    end
                end
                S_LOAD, S_UNLOAD: begin
                    // Outgoing MSB feeds the chain while the chain tail refills the LSB
                    sreg <= {sreg[CHAIN_LEN-2:0], WPSO};
                    cnt  <= last_shift ? '0 : cnt + CNT_W'(1);
                end
                S_CAPTURE: begin
                    cnt <= '0;
                end
                S_DONE: begin
                    response <= sreg;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
                    fail     <= |((sreg ^ expected_q) & mask_q);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wbr_scan_ctrl.sv
// Testbench for wbr_scan_ctrl: drives a behavioural WC_SF1_CII chain and
// checks each test against outcome-level expectations (phase timing, serial
// stream, response, final chain content). Define WBR_SCAN_CTRL_COMPARE_EN to
// also exercise the compare/fail logic.
module tb_wbr_scan_ctrl;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         resetn;
    logic         start;
    logic         abort;
    logic         capture_en;
    logic [N-1:0] pattern;
    logic         wse_outputs;
    logic         hold_outputs;
    logic         WPSI;
    logic         WPSO;
    logic [N-1:0] response;
    logic         busy;
    logic         done;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
    logic [N-1:0] expected;
    logic [N-1:0] mask;
    logic         fail;
`endif

    // Chain model state
    logic [N-1:0] chain;
    logic [N-1:0] core;
    logic [N-1:0] preset_val;
    logic         preset_now;

    // Bench-side expectations of the held results
    logic [N-1:0] model_resp;
    logic         model_fail;

    int total = 0;
    int bad   = 0;

    wbr_scan_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .capture_en   (capture_en),
        .pattern      (pattern),
`ifdef WBR_SCAN_CTRL_COMPARE_EN
        .expected     (expected),
        .mask         (mask),
        .fail         (fail),
`endif
        .wse_outputs  (wse_outputs),
        .hold_outputs (hold_outputs),
        .WPSI         (WPSI),
        .WPSO         (WPSO),
        .response     (response),
        .busy         (busy),
        .done         (done)
    );

    always #5 CLK = ~CLK;

    // WC_SF1_CII chain: shift when wse, capture core data when neither wse nor hold
    assign WPSO = chain[N-1];
    always @(posedge CLK) begin
        if (preset_now)         chain <= preset_val;
        else if (wse_outputs)   chain <= {chain[N-2:0], WPSI};
        else if (!hold_outputs) chain <= core;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // One test. Cycle k = k-th cycle after the accepting edge.
    // abort_k > 0 raises abort during cycle abort_k.
    task automatic run_test(input logic [N-1:0] pre, input logic [N-1:0] pat,
                            input logic [N-1:0] cor, input bit cap,
                            input int abort_k, input bit busy_start,
                            input logic [N-1:0] e, input logic [N-1:0] m);
        int           done_k;
        int           last_k;
        int           ph;      // 0 idle, 1 load, 2 capture, 3 unload, 4 done
        logic         x_wse, x_hold, x_busy, x_done;
        logic [N-1:0] new_resp;
        logic         new_fail;
        logic [N-1:0] x_resp;
        logic         x_fail;
        bit           aborted;

        new_resp = cap ? cor : pre;
        new_fail = |((new_resp ^ e) & m);
        done_k   = cap ? 2*N + 2 : N + 1;
        last_k   = (abort_k > 0) ? abort_k + 3 : done_k + 2;

        @(negedge CLK);
        preset_val = pre;
        preset_now = 1'b1;
        core       = cor;
        @(negedge CLK);
        preset_now = 1'b0;
        pattern    = pat;
        capture_en = cap;
        start      = 1'b1;
        abort      = 1'b0;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
        expected   = e;
        mask       = m;
`endif
        for (int k = 1; k <= last_k; k++) begin
            @(negedge CLK);
            start      = 1'b0;
            abort      = 1'b0;
            pattern    = N'($urandom);
            capture_en = ~cap;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
            expected   = N'($urandom);
            mask       = N'($urandom);
`endif
            aborted = (abort_k > 0) && (k > abort_k);
            if (aborted)                   ph = 0;
            else if (k <= N)               ph = 1;
            else if (cap && k == N + 1)    ph = 2;
            else if (cap && k <= 2*N + 1)  ph = 3;
            else if (k == done_k)          ph = 4;
            else                           ph = 0;

            x_wse  = (ph == 1) || (ph == 3);
            x_hold = (ph == 0) || (ph == 4);
            x_busy = (ph >= 1) && (ph <= 3);
            x_done = (ph == 4);
            chk("wse",  64'(wse_outputs),  64'(x_wse));
            chk("hold", 64'(hold_outputs), 64'(x_hold));
            chk("busy", 64'(busy),         64'(x_busy));
            chk("done", 64'(done),         64'(x_done));

            // Serial stream: pattern MSB first, then the pre-test content back in
            if (ph == 1)
                chk("wpsi_load", 64'(WPSI), 64'(bit_of(pat, N - k)));
            else if (ph == 2)
                chk("wpsi_cap", 64'(WPSI), 64'(bit_of(pre, N - 1)));
            else if (ph == 3)
                chk("wpsi_unload", 64'(WPSI), 64'(bit_of(pre, 2*N + 1 - k)));
            else if (!aborted)
                chk("wpsi_end", 64'(WPSI), 64'(bit_of(new_resp, N - 1)));

            if (ph == 2)
                chk("dout_cap", 64'(chain), 64'(pat));

            x_resp = (aborted || k <= done_k) ? model_resp : new_resp;
            x_fail = (aborted || k <= done_k) ? model_fail : new_fail;
            chk("response", 64'(response), 64'(x_resp));
`ifdef WBR_SCAN_CTRL_COMPARE_EN
            chk("fail", 64'(fail), 64'(x_fail));
`endif
            if (!aborted && k == done_k + 1)
                chk("chain_end", 64'(chain), 64'(cap ? pre : pat));

            if (k == abort_k) abort = 1'b1;
            if (busy_start && k == 3) begin
                start   = 1'b1;
                pattern = '1;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (abort_k == 0) begin
            model_resp = new_resp;
            model_fail = new_fail;
        end
    endtask

    initial begin
        int           ak;
        bit           cp;
        bit           bs;
        logic [N-1:0] rp;

        resetn     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        capture_en = 1'b0;
        pattern    = '0;
        core       = '0;
        preset_val = '0;
        preset_now = 1'b1;
        model_resp = '0;
        model_fail = 1'b0;
`ifdef WBR_SCAN_CTRL_COMPARE_EN
        expected   = '0;
        mask       = '0;
`endif
        repeat (3) @(negedge CLK);
        resetn     = 1'b1;
        preset_now = 1'b0;

        // Reset state held through idle cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("rst_wse",  64'(wse_outputs),  64'(0));
            chk("rst_hold", 64'(hold_outputs), 64'(1));
            chk("rst_busy", 64'(busy),         64'(0));
            chk("rst_done", 64'(done),         64'(0));
            chk("rst_resp", 64'(response),     64'(0));
            chk("rst_wpsi", 64'(WPSI),         64'(0));
`ifdef WBR_SCAN_CTRL_COMPARE_EN
            chk("rst_fail", 64'(fail),         64'(0));
`endif
        end

        // Directed cases
        run_test(8'h00, 8'h3C, 8'hA5, 1'b1, 0, 1'b0, 8'hA4, 8'hFF);
        run_test(8'h00, 8'h3C, 8'hA5, 1'b1, 0, 1'b0, 8'hA4, 8'hFE);
        run_test(8'h5A, 8'hC3, 8'hA5, 1'b0, 0, 1'b0, 8'h5A, 8'hFF);
        run_test(8'h33, 8'h96, 8'h0F, 1'b1, 4, 1'b0, 8'h00, 8'hFF);
        run_test(8'h81, 8'h7E, 8'h69, 1'b1, 0, 1'b1, 8'h00, 8'h00);

        // Simultaneous start and abort in IDLE: no test starts
        @(negedge CLK);
        pattern = 8'hF0;
        start   = 1'b1;
        abort   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            start = 1'b0;
            abort = 1'b0;
            chk("sa_busy", 64'(busy),        64'(0));
            chk("sa_wse",  64'(wse_outputs), 64'(0));
            chk("sa_done", 64'(done),        64'(0));
            chk("sa_resp", 64'(response),    64'(model_resp));
        end

        // Randomized tests
        for (int n = 0; n < 40; n++) begin
            cp = 1'($urandom);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cp ? 2*N + 1 : N) : 0;
            bs = (ak == 0) && ($urandom_range(0, 2) == 0);
            run_test(N'($urandom), N'($urandom), N'($urandom), cp, ak, bs,
                     N'($urandom), N'($urandom));
        end

        // Reset mid-operation clears response and returns to idle
        @(negedge CLK);
        rp         = 8'hE7;
        pattern    = rp;
        capture_en = 1'b1;
        start      = 1'b1;
        repeat (5) @(negedge CLK);
        start  = 1'b0;
        resetn = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
        chk("mrst_busy", 64'(busy),         64'(0));
        chk("mrst_wse",  64'(wse_outputs),  64'(0));
        chk("mrst_hold", 64'(hold_outputs), 64'(1));
        chk("mrst_resp", 64'(response),     64'(0));
`ifdef WBR_SCAN_CTRL_COMPARE_EN
        chk("mrst_fail", 64'(fail),         64'(0));
`endif
        model_resp = '0;
        model_fail = 1'b0;
        run_test(8'h12, 8'h34, 8'h56, 1'b1, 0, 1'b0, 8'h56, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
